adc_period_meter: RTL

Measures the frequency of a sampled analog signal returning from the ADC, the receive-side counterpart of the sine DDS that drives the DAC. A hysteretic mid-scale crossing detector finds rising crossings, and a period counter sums clk cycles over NPER consecutive periods. Software or the top-level controller reads `period_sum` and derives frequency as NPER·f_clk / period_sum. The DDS loopback path uses this to close the frequency-word calibration loop.

---
 rtl/adc_meas_pkg.sv | 24 ++
 rtl/schmitt_xdet.sv | 70 +++++++
 rtl/adc_period_meter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_meas_pkg.sv
// ============================================================================
//  Module      : adc_meas_pkg
//  Description : Types and constants shared by the ADC period-measurement
//                path and the DDS/DAC side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_meas_pkg;

    // Sample format shared with the DDS/DAC side
    localparam int DATA_W    = 12;
    localparam int MID_SCALE = 2048;

    // Measurement controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } meas_state_t;

endpackage

`default_nettype wire

// File: rtl/schmitt_xdet.sv
// ============================================================================
//  Module      : schmitt_xdet
//  Description : Input sample register, hysteretic mid-scale comparator and
//                rising-crossing pulse generator. Sample-to-xr latency is two
//                clocks: one for the input register, one for the hysteresis
//                state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module schmitt_xdet #(
    parameter int DATA_W = 12,
    parameter int MID    = 2048,
    parameter int HYST   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic [DATA_W-1:0] sample,
    output logic              sample_vld,
    output logic              xr
);

    localparam int c_thr_hi = MID + HYST;
    localparam int c_thr_lo = MID - HYST;

    logic [DATA_W-1:0] r_sample;
    logic              r_sample_vld;
    logic              r_high;
    logic              r_xr;
    logic              w_above;
    logic              w_below;

    // Thresholds compared in signed int so MID-HYST below zero stays sane
    assign w_above = (int'({1'b0, r_sample}) >= c_thr_hi);
    assign w_below = (int'({1'b0, r_sample}) <= c_thr_lo);

    // Capture valid samples; the hysteresis state only moves on a fresh
    // sample so adc_valid=0 freezes the detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample     <= '0;
            r_sample_vld <= 1'b0;
            r_high       <= 1'b0;
            r_xr         <= 1'b0;
        end else begin
            if (adc_valid) begin
                r_sample <= adc_data;
            end
            r_sample_vld <= adc_valid;
            r_xr         <= 1'b0;
            if (r_sample_vld) begin
                if (w_above) begin
                    r_high <= 1'b1;
                    r_xr   <= ~r_high;
                end else if (w_below) begin
                    r_high <= 1'b0;
                end
            end
        end
    end

    assign sample     = r_sample;
    assign sample_vld = r_sample_vld;
    assign xr         = r_xr;

endmodule

`default_nettype wire

// File: rtl/adc_period_meter.sv
// ============================================================================
//  Module      : adc_period_meter
//  Description : Measures the clk-cycle span of NPER consecutive periods of
//                the sampled ADC signal, with a gap timeout. Optional peak
//                detector reports peak-to-peak amplitude of the window.
//                Optional feature macro: ADC_PEAK_DETECT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_period_meter #(
    parameter int          DATA_W      = adc_meas_pkg::DATA_W,
    parameter int          MID         = adc_meas_pkg::MID_SCALE,
    parameter int          HYST        = 32,
    parameter int          NPER        = 16,
    parameter int          CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  period_sum,
    output logic [DATA_W-1:0] vpp
);

    import adc_meas_pkg::*;

    localparam int                 c_k_w      = (NPER > 1) ? $clog2(NPER) : 1;
    localparam logic [c_k_w-1:0]   c_k_last   = c_k_w'(NPER - 1);
    localparam logic [CNT_W-1:0]   c_gap_last = CNT_W'(TIMEOUT_CYC - 32'd1);

    meas_state_t        r_state;
    meas_state_t        w_state_next;
    logic [CNT_W-1:0]   r_cyc;
    logic [CNT_W-1:0]   r_gap;
    logic [c_k_w-1:0]   r_k;
    logic               r_done;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_period_sum;

    logic               w_xr;
    logic [DATA_W-1:0]  w_sample;
    logic               w_sample_vld;
    logic               w_gap_full;
    logic               w_arm;
    logic               w_finish_ok;
    logic               w_finish_to;

    schmitt_xdet #(
        .DATA_W (DATA_W),
        .MID    (MID),
        .HYST   (HYST)
    ) u_xdet (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .sample     (w_sample),
        .sample_vld (w_sample_vld),
        .xr         (w_xr)
    );

    // Gap counter is about to reach TIMEOUT_CYC on this edge
    assign w_gap_full = (r_gap == c_gap_last);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control strobes; a crossing beats a same-cycle timeout
    always_comb begin
        w_state_next = r_state;
        w_arm        = 1'b0;
        w_finish_ok  = 1'b0;
        w_finish_to  = 1'b0;
        case (r_state)
            IDLE: begin
                // start coinciding with the done pulse is dropped
                if (start && !r_done) begin
                    w_state_next = ARM;
                end
            end
            ARM: begin
                if (w_xr) begin
                    w_arm        = 1'b1;
                    w_state_next = MEAS;
                end else if (w_gap_full) begin
                    w_finish_to  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            MEAS: begin
                if (w_xr && (r_k == c_k_last)) begin
                    w_finish_ok  = 1'b1;
                    w_state_next = IDLE;
                end else if (!w_xr && w_gap_full) begin
                    w_finish_to  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Gap, period and crossing counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap <= '0;
            r_cyc <= '0;
            r_k   <= '0;
        end else begin
            if ((r_state == IDLE) || w_xr) begin
                r_gap <= '0;
            end else begin
                r_gap <= r_gap + CNT_W'(1);
            end
            if (w_arm) begin
                r_cyc <= '0;
                r_k   <= '0;
            end else if (r_state == MEAS) begin
                r_cyc <= r_cyc + CNT_W'(1);
                if (w_xr) begin
                    r_k <= r_k + c_k_w'(1);
                end
            end
        end
    end

    // Result registers; they hold until the next done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_period_sum <= '0;
        end else begin
            r_done <= w_finish_ok | w_finish_to;
            if (w_finish_ok) begin
                r_period_sum <= r_cyc + CNT_W'(1);
                r_timeout    <= 1'b0;
            end else if (w_finish_to) begin
                r_period_sum <= '0;
                r_timeout    <= 1'b1;
            end
        end
    end

`ifdef ADC_PEAK_DETECT_EN
    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] r_vpp;

    // Running min/max over the window, seeded from the arming sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min <= '0;
            r_max <= '0;
            r_vpp <= '0;
        end else begin
            if (w_arm) begin
                r_min <= w_sample;
                r_max <= w_sample;
            end else if ((r_state == MEAS) && w_sample_vld) begin
                if (w_sample < r_min) begin
                    r_min <= w_sample;
                end
                if (w_sample > r_max) begin
                    r_max <= w_sample;
                end
            end
            if (w_finish_ok) begin
                r_vpp <= r_max - r_min;
            end else if (w_finish_to) begin
                r_vpp <= '0;
            end
        end
    end

    assign vpp = r_vpp;
`else
    logic w_unused_peak;
    assign w_unused_peak = ^{w_sample, w_sample_vld};
    assign vpp           = '0;
`endif

    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign period_sum = r_period_sum;

endmodule

`default_nettype wire
